// File: rtl/flush_ctrl_if.sv
// Commit-side flush/redirect bundle between the WB stage, fetch unit and flush_ctrl.
// master drives commit and fetch events; slave (flush_ctrl) drives flush/redirect results.
interface flush_ctrl_if;
  logic        wb_ex;
  logic        ertn_flush;
  logic        wb_refetch_flush;
  logic [5:0]  wb_ecode;
  logic [31:0] wb_pc;
  logic [31:0] csr_eentry;
  logic [31:0] csr_tlbrentry;
  logic [31:0] csr_era;
  logic        if_req_fire;
  logic        if_resp_fire;
  logic        redirect_ready;
  logic        flush_all;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        resp_discard;
  logic        busy;

  modport master (
    output wb_ex, ertn_flush, wb_refetch_flush, wb_ecode, wb_pc,
           csr_eentry, csr_tlbrentry, csr_era,
           if_req_fire, if_resp_fire, redirect_ready,
    input  flush_all, redirect_valid, redirect_pc, resp_discard, busy
  );

  modport slave (
    input  wb_ex, ertn_flush, wb_refetch_flush, wb_ecode, wb_pc,
           csr_eentry, csr_tlbrentry, csr_era,
           if_req_fire, if_resp_fire, redirect_ready,
    output flush_all, redirect_valid, redirect_pc, resp_discard, busy
  );
endinterface

// File: rtl/flush_ctrl.sv
// Pipeline flush and fetch redirect on WB commit of exception/ertn/refetch; flush_all is same-cycle,
// redirect is registered and held until pre-IF accepts it; in-flight fetches at the flush are discarded.
module flush_ctrl (
  input  logic       clk,
  input  logic       reset,
  flush_ctrl_if.slave fc
);

  typedef enum logic {IDLE = 1'b0, PEND = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic [1:0]  out_cnt_q, out_cnt_d;
  logic [1:0]  disc_cnt_q, disc_cnt_d;
  logic        trigger;
  logic        resp_drop;
  logic [31:0] target;

  assign trigger   = fc.wb_ex | fc.ertn_flush | fc.wb_refetch_flush;
  assign resp_drop = fc.if_resp_fire & (disc_cnt_q != 2'd0);

  always_comb begin
    target = fc.wb_pc + 32'd4;
    if (fc.wb_ex)
      target = (fc.wb_ecode == 6'h3F) ? fc.csr_tlbrentry : fc.csr_eentry;
    else if (fc.ertn_flush)
      target = fc.csr_era;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      redirect_pc_q <= 32'h0;
      out_cnt_q     <= 2'd0;
      disc_cnt_q    <= 2'd0;
    end else begin
      state_q       <= state_d;
      redirect_pc_q <= redirect_pc_d;
      out_cnt_q     <= out_cnt_d;
      disc_cnt_q    <= disc_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (trigger) state_d = PEND;
      PEND: begin
        if (trigger)                  state_d = PEND;
        else if (fc.redirect_ready)   state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    redirect_pc_d = trigger ? target : redirect_pc_q;

    out_cnt_d = out_cnt_q;
    if (fc.if_req_fire && !fc.if_resp_fire && out_cnt_q != 2'd3)
      out_cnt_d = out_cnt_q + 2'd1;
    else if (!fc.if_req_fire && fc.if_resp_fire && out_cnt_q != 2'd0)
      out_cnt_d = out_cnt_q - 2'd1;

    // Everything in flight at the flush, including this cycle's accepted request, is wrong-path.
    disc_cnt_d = disc_cnt_q;
    if (trigger)
      disc_cnt_d = out_cnt_d;
    else if (resp_drop)
      disc_cnt_d = disc_cnt_q - 2'd1;
  end

  always_comb begin
    fc.flush_all      = trigger;
    fc.redirect_valid = (state_q == PEND);
    fc.redirect_pc    = redirect_pc_q;
    fc.resp_discard   = resp_drop;
    fc.busy           = (state_q == PEND) | (disc_cnt_q != 2'd0);
  end

endmodule

// File: doc/flush_ctrl.md
FLUSH_CTRL -- requirements
Module: flush_ctrl

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-002 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port wb_ex  input  1  WB-stage exception commit.
REQ-004 SHALL have port ertn_flush  input  1  WB-stage ertn commit.
REQ-005 SHALL have port wb_refetch_flush  input  1  WB-stage refetch commit (TLB/CSR side effects).
REQ-006 SHALL have port wb_ecode  input  6  exception code; 6'h3F means TLB refill.
REQ-007 SHALL have port wb_pc  input  32  PC of the committing WB instruction.
REQ-008 SHALL have ports csr_eentry, csr_tlbrentry, csr_era  input  32 each  CSR targets.
REQ-009 SHALL have port if_req_fire  input  1  inst_sram req & addr_ok this cycle.
REQ-010 SHALL have port if_resp_fire  input  1  inst_sram data_ok this cycle.
REQ-011 SHALL have port redirect_ready  input  1  pre-IF issued the redirected fetch this cycle.
REQ-012 SHALL have port flush_all  output  1  clears valid in IF/ID/EX/MEM this cycle.
REQ-013 SHALL have port redirect_valid  output  1  redirect target pending.
REQ-014 SHALL have port redirect_pc  output  32  registered redirect target.
REQ-015 SHALL have port resp_discard  output  1  current data_ok belongs to a cancelled fetch; drop it.
REQ-016 SHALL have port busy  output  1  redirect pending or discards outstanding.

Function
REQ-017 SHALL define trigger = wb_ex | ertn_flush | wb_refetch_flush; flush_all = trigger, combinational, same cycle.
REQ-018 SHALL select target by priority wb_ex > ertn_flush > wb_refetch_flush when several are asserted together.
REQ-019 SHALL use target: wb_ex -> (wb_ecode==6'h3F ? csr_tlbrentry : csr_eentry); ertn -> csr_era; refetch -> wb_pc+32'd4, modulo 2^32.
REQ-020 SHALL implement two states: IDLE (redirect_valid=0) and PEND (redirect_valid=1).
REQ-021 SHALL on trigger in any state: next state PEND, redirect_pc <= target; redirect_valid rises the cycle after trigger.
REQ-022 SHALL in PEND with redirect_ready=1 and no trigger: return to IDLE next cycle; redirect_pc holds its value.
REQ-023 SHALL on trigger coinciding with redirect_ready: new target wins; remain PEND.
REQ-024 SHALL ignore redirect_ready in IDLE.
REQ-025 SHALL keep a 2-bit outstanding counter: next = cnt + if_req_fire - if_resp_fire, saturating at 0 and 3.
REQ-026 SHALL keep a 2-bit discard counter; on trigger load it with the outstanding counter's next value, including a request accepted in the trigger cycle.
REQ-027 SHALL assert resp_discard = if_resp_fire & (discard!=0) combinationally; without trigger, decrement discard on each such cycle.
REQ-028 SHALL never discard the redirected fetch: requests accepted after the trigger cycle increment outstanding only.
REQ-029 SHALL drive busy = (state==PEND) | (discard!=0).

Reset
REQ-030 SHALL on reset force state IDLE, redirect_pc=32'h0, outstanding=0, discard=0; outputs redirect_valid=0, resp_discard=0, busy=0, independent of clk.
REQ-031 SHALL leave flush_all combinational during reset (follows trigger inputs).
REQ-032 SHALL on reset mid-PEND or mid-discard drop all pending state immediately; no redirect is issued after release.

Verification
REQ-033 SHALL cover: wb_ex, wb_ecode=6'h08, csr_eentry=32'h1C008000 -> flush_all=1 that cycle; next cycle redirect_valid=1, redirect_pc=32'h1C008000.
REQ-034 SHALL cover: wb_ex, wb_ecode=6'h3F, csr_tlbrentry=32'h1C00F000 -> redirect_pc=32'h1C00F000; refetch with wb_pc=32'hFFFFFFFC -> redirect_pc=32'h0.
REQ-035 SHALL cover: 2 outstanding, trigger with if_req_fire=1 -> discard=3; next three data_ok pulses give resp_discard=1; fourth data_ok (redirected fetch) gives resp_discard=0.
REQ-036 SHALL cover: PEND for 5 cycles of redirect_ready=0 then 1 -> redirect_valid holds then drops next cycle; second trigger during PEND overwrites redirect_pc.
REQ-037 SHALL cover: wb_ex and wb_refetch_flush together -> exception target chosen; reset asserted in PEND -> redirect_valid=0, busy=0 immediately.
